bcd_display_ctrl: RTL and testbench

//  Sequential binary-to-BCD converter and display loader for the 8-digit seven-segment driver.
//  It accepts a binary value over a valid/ready handshake and converts it by iterative

---
 rtl/bcd_display_ctrl.sv | 105 ++++++++++
 tb/tb_bcd_display_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_ctrl
// Description : Sequential double-dabble binary-to-BCD converter that loads
//               8 registered digits for a seven-segment driver.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_ctrl #(
  parameter int WIDTH = 27
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             In_Valid,
  input  logic [WIDTH-1:0] In_Data,
  output logic             In_Ready,
  output logic [31:0]      BCD,
  output logic             Done,
  output logic             Overflow
);

  localparam int          CNT_W   = $clog2(WIDTH + 1);
  localparam logic [31:0] MAX_DEC = 32'd99_999_999;
  localparam logic [31:0] SAT_BCD = 32'h9999_9999;

  generate
    if (WIDTH < 4 || WIDTH > 27) begin : g_bad_width
      $error("bcd_display_ctrl: WIDTH must be in 4..27");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] bin;
  logic [31:0]      scratch;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [31:0]      adjusted;
  logic [31:0]      data_ext;

  assign data_ext = 32'(In_Data);

  // Add-3 correction on every nibble before the shift; a carry out of nibble 7
  // can only occur for out-of-range values, which are replaced by saturation.
  generate
    for (genvar i = 0; i < 8; i++) begin : g_adj
      assign adjusted[4*i +: 4] = (scratch[4*i +: 4] >= 4'd5) ?
                                  scratch[4*i +: 4] + 4'd3 : scratch[4*i +: 4];
    end
  endgenerate

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      In_Ready <= 1'b1;
      Done     <= 1'b0;
      BCD      <= 32'h0;
      Overflow <= 1'b0;
      bin      <= '0;
      scratch  <= 32'h0;
      cnt      <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (In_Valid) begin
            bin      <= In_Data;
            scratch  <= 32'h0;
            cnt      <= CNT_W'(WIDTH);
            ovf      <= (data_ext > MAX_DEC);
            In_Ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= 32'({adjusted, bin[WIDTH-1]});
          bin     <= {bin[WIDTH-2:0], 1'b0};
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            Done  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          BCD      <= ovf ? SAT_BCD : scratch;
          Overflow <= ovf;
          Done     <= 1'b0;
          In_Ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          Done     <= 1'b0;
          In_Ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_ctrl.sv
`default_nettype none
// Testbench for bcd_display_ctrl: scoreboard of expected digit loads checked
// on the cycle after each Done pulse.
module tb_bcd_display_ctrl;

  localparam int WIDTH = 27;
  localparam int LAT   = WIDTH + 1;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             In_Valid;
  logic [WIDTH-1:0] In_Data;
  logic             In_Ready;
  logic [31:0]      BCD;
  logic             Done;
  logic             Overflow;

  bcd_display_ctrl #(.WIDTH(WIDTH)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .In_Valid (In_Valid),
    .In_Data  (In_Data),
    .In_Ready (In_Ready),
    .BCD      (BCD),
    .Done     (Done),
    .Overflow (Overflow)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    r = 32'h0;
    x = v;
    if (v > 99_999_999) return 32'h9999_9999;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Monitor: BCD may change only on the cycle after Done, when it must match
  // the oldest outstanding expectation.
  logic        prev_done = 1'b0;
  logic [31:0] prev_bcd  = 32'h0;
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset) begin
      prev_done = 1'b0;
      prev_bcd  = BCD;
    end else begin
      if (prev_done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("bcd", BCD, e.bcd);
          check("overflow", Overflow, e.ovf);
          check("latency", cyc - e.acc, LAT);
        end
        check("done_width", Done, 0);
      end else begin
        check("bcd_hold", BCD, prev_bcd);
      end
      prev_done = Done;
      prev_bcd  = BCD;
    end
  end

  // Presents a value, waits for a ready cycle, and returns the accepting cycle.
  task automatic send(input int unsigned v, output int acc);
    int n;
    exp_t e;
    n = 0;
    @(negedge Clk);
    while (!In_Ready && n < 200) begin
      n++;
      @(negedge Clk);
    end
    if (n >= 200) check("ready_timeout", 1, 0);
    In_Valid = 1'b1;
    In_Data  = WIDTH'(v);
    @(posedge Clk);
    #1;
    acc   = cyc;
    e.bcd = to_bcd(v);
    e.ovf = (v > 99_999_999);
    e.acc = acc;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      n++;
      @(negedge Clk);
    end
    if (sb.size() != 0) check("drain_timeout", 1, 0);
    @(negedge Clk);
  endtask

  initial begin
    int acc, acc2, n;
    int unsigned rv;
    Reset    = 1'b0;
    In_Valid = 1'b0;
    In_Data  = '0;
    #23;
    check("rst_bcd", BCD, 0);
    check("rst_done", Done, 0);
    check("rst_ovf", Overflow, 0);
    check("rst_ready", In_Ready, 1);
    @(posedge Clk);
    #2 Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("idle_ready", In_Ready, 1);
    check("idle_done", Done, 0);

    send(12_345_678, acc);
    In_Valid = 1'b0;
    n = 0;
    @(negedge Clk);
    while (!In_Ready && n < 100) begin
      n++;
      @(negedge Clk);
    end
    check("ready_low_cycles", n, LAT);
    drain();

    send(0, acc);
    In_Valid = 1'b0;
    drain();
    send(99_999_999, acc);
    In_Valid = 1'b0;
    drain();

    send(100_000_000, acc);
    In_Valid = 1'b0;
    drain();
    send(42, acc);
    In_Valid = 1'b0;
    drain();

    for (int i = 0; i < 4; i++) begin
      rv = (i == 3) ? $urandom_range(100_000_001, 134_217_727) : $urandom_range(0, 99_999_999);
      send(rv, acc);
      In_Valid = 1'b0;
      drain();
    end

    send(7, acc);
    send(89, acc2);
    In_Valid = 1'b0;
    check("b2b_spacing", acc2 - acc, LAT + 1);
    repeat (10) @(negedge Clk);
    check("b2b_hold", BCD, 32'h7);
    drain();

    send(12_345, acc);
    In_Valid = 1'b0;
    repeat (10) @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("abort_bcd", BCD, 0);
    check("abort_done", Done, 0);
    check("abort_ready", In_Ready, 1);
    check("abort_ovf", Overflow, 0);
    sb.delete();
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b1;
    repeat (40) @(negedge Clk);
    check("abort_bcd_after", BCD, 0);
    send(5, acc);
    In_Valid = 1'b0;
    drain();
    check("final_bcd", BCD, 32'h5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
